// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin front end for the shared iterative multiplier.
//
// Two requesters compete for one multiplier. The winner's operands,
// opcode and tag are latched, handed to the multiplier, and the result is
// returned with the tag on the winner's response port. Only one operation
// is outstanding at a time. A flush abandons the current operation. If the
// multiplier already holds that operation, its result is drained and
// dropped.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   flush                 single-cycle kill of the accepted/in-flight op
//   reqN_valid/ready      request handshake (ready = accepted this cycle)
//   reqN_a/b/op/tag       request payload, stable while valid && !ready
//   rspN_valid/ready      registered response handshake
//   rspN_result/tag       response payload
//   mul_in_valid/ready    multiplier input handshake
//   mul_a/b/op            latched operands and opcode for the multiplier
//   mul_out_valid/ready   multiplier result handshake
//   mul_out_result        multiplier result
//   busy                  high whenever the sequencer is not idle

package riscv_mul_pkg;
  typedef enum logic [2:0] {
    MUL_NONE = 3'd0,
    MUL      = 3'd1,
    MULH     = 3'd2,
    MULHSU   = 3'd3,
    MULHU    = 3'd4
  } riscv_mul_op_e;
endpackage

module mul_arbiter
  import riscv_mul_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  riscv_mul_op_e    req0_op,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  riscv_mul_op_e    req1_op,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_result,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_result,
  output logic [TAG_W-1:0] rsp1_tag,
  output logic             mul_in_valid,
  input  logic             mul_in_ready,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output riscv_mul_op_e    mul_op,
  input  logic             mul_out_valid,
  output logic             mul_out_ready,
  input  logic [31:0]      mul_out_result,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_e;

  state_e           state;
  logic             prio;        // requester that wins the next tie
  logic             owner;       // requester of the operation in flight
  logic [TAG_W-1:0] tag_q;
  logic             mul_in_valid_q;

  logic             grant_valid;
  logic             grant;

  // Grant selection: only in IDLE and never during a flush. A tie goes to prio.
  always_comb begin
    grant_valid = 1'b0;
    grant       = 1'b0;
    if (state == IDLE && !flush) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant       = prio;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant       = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant       = 1'b1;
      end else begin
        grant_valid = 1'b0;
        grant       = 1'b0;
      end
    end else begin
      grant_valid = 1'b0;
      grant       = 1'b0;
    end
  end

  assign req0_ready = grant_valid & ~grant;
  assign req1_ready = grant_valid & grant;

  // A flush in ISSUE must keep the handshake from happening in that same cycle.
  assign mul_in_valid = mul_in_valid_q & ~flush;
  assign busy         = (state != IDLE);

  // Sequencer FSM with its registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      prio           <= 1'b0;
      owner          <= 1'b0;
      tag_q          <= '0;
      mul_a          <= 32'd0;
      mul_b          <= 32'd0;
      mul_op         <= MUL_NONE;
      mul_in_valid_q <= 1'b0;
      mul_out_ready  <= 1'b0;
      rsp0_valid     <= 1'b0;
      rsp0_result    <= 32'd0;
      rsp0_tag       <= '0;
      rsp1_valid     <= 1'b0;
      rsp1_result    <= 32'd0;
      rsp1_tag       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner          <= grant;
            prio           <= ~grant;
            mul_a          <= grant ? req1_a   : req0_a;
            mul_b          <= grant ? req1_b   : req0_b;
            mul_op         <= grant ? req1_op  : req0_op;
            tag_q          <= grant ? req1_tag : req0_tag;
            mul_in_valid_q <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (flush) begin
            mul_in_valid_q <= 1'b0;
            state          <= IDLE;
          end else if (mul_in_ready) begin
            mul_in_valid_q <= 1'b0;
            mul_out_ready  <= 1'b1;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (flush) begin
            // A result that arrives in the flush cycle is consumed here and
            // dropped, so there is nothing left to drain.
            if (mul_out_valid) begin
              mul_out_ready <= 1'b0;
              state         <= IDLE;
            end else begin
              state         <= DRAIN;
            end
          end else if (mul_out_valid) begin
            mul_out_ready <= 1'b0;
            if (owner) begin
              rsp1_valid  <= 1'b1;
              rsp1_result <= mul_out_result;
              rsp1_tag    <= tag_q;
            end else begin
              rsp0_valid  <= 1'b1;
              rsp0_result <= mul_out_result;
              rsp0_tag    <= tag_q;
            end
            state <= RESP;
          end
        end
        RESP: begin
          if (flush || (owner ? rsp1_ready : rsp0_ready)) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        DRAIN: begin
          if (mul_out_valid) begin
            mul_out_ready <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          mul_in_valid_q <= 1'b0;
          mul_out_ready  <= 1'b0;
          rsp0_valid     <= 1'b0;
          rsp1_valid     <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin arbiter and sequencer that shares the single iterative Booth multiplier between two requesters (e.g. two issue slots or the EXU and a microcoded helper). It accepts one operation at a time, latches its operands, drives the multiplier's input handshake, captures the result and returns it with the requester's tag on that requester's response port. A pipeline flush aborts the in-flight operation and silently drains the multiplier.

## Interface
- TAG_W, 4, width of the opaque requester tag returned with each result.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  single-cycle kill of any accepted/in-flight operation.
- reqN_valid  in  1  request N (N=0,1) valid.
- reqN_ready  out  1  request N accepted this cycle.
- reqN_a, reqN_b  in  32  operands A, B.
- reqN_op  in  riscv_mul_op_e  MUL/MULH/MULHSU/MULHU.
- reqN_tag  in  TAG_W  tag echoed on response.
- rspN_valid  out  1  response N valid (registered).
- rspN_ready  in  1  requester N consumes response.
- rspN_result  out  32  result.
- rspN_tag  out  TAG_W  tag of the original request.
- mul_in_valid  out  1  to multiplier input valid.
- mul_in_ready  in  1  from multiplier input ready.
- mul_a, mul_b  out  32  latched operands.
- mul_op  out  riscv_mul_op_e  latched opcode.
- mul_out_valid  in  1  multiplier result valid.
- mul_out_ready  out  1  arbiter takes result.
- mul_out_result  in  32  multiplier result.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN. One operation outstanding at most.
- IDLE: grant = only valid requester; if both valid, grant requester indicated by prio (reset 0). reqG_ready=1 for grant only; latch a, b, op, tag, owner=G; prio <= ~G; go ISSUE. Non-granted ready=0. flush in IDLE: no grant, both ready=0, prio unchanged.
- ISSUE: mul_in_valid=1 with latched fields; on mul_in_ready go WAIT. flush: mul_in_valid forced 0 that cycle, go IDLE (nothing issued).
- WAIT: mul_out_ready=1; on mul_out_valid capture mul_out_result, go RESP. flush: go DRAIN (flush wins over a same-cycle mul_out_valid: result discarded, go IDLE instead).
- RESP: rsp[owner]_valid=1 with captured result and tag; other rsp_valid=0; on rsp[owner]_ready go IDLE. flush: drop valid, go IDLE.
- DRAIN: mul_out_ready=1; on mul_out_valid go IDLE; no response produced; further flush ignored.
- Multiplier opcode and operands passed unmodified; arbiter does no arithmetic.
- Request payload must be stable while reqN_valid=1 and ready=0 (requester obligation; not checked).

## Timing
- Reset: state IDLE, prio 0, all outputs 0 (reqN_ready, rspN_valid, rspN_result, rspN_tag, mul_in_valid, mul_a, mul_b, mul_out_ready, busy), mul_op = MUL_NONE. rst mid-operation: arbiter returns to IDLE next cycle; multiplier is reset by the same rst.
- Request accept cycle T (IDLE); mul handshake no earlier than T+1; result capture cycle C = mul_out_valid cycle; rsp_valid from C+1.
- With the Booth multiplier (ready in its IDLE, out_valid 34 cycles after input handshake): accept at T -> rsp_valid at T+36 if rsp_ready held high; next accept no earlier than T+37.
- Response held stable until rsp_ready; backpressure stalls the multiplier (it sits in DONE until WAIT/DRAIN, arbiter holds mul_out_ready low only in RESP—which cannot coincide with mul_out_valid).
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- busy combinationally equals state != IDLE.

## Test plan
- Single req0: a=7, b=-3 (0xFFFFFFFD), op=MUL, tag=5, accepted at T -> rsp0_valid at T+36, rsp0_result=0xFFFFFFEB, rsp0_tag=5; rsp1_valid stays 0.
- Both valid continuously after reset: req0 MULHU(0xFFFFFFFF,0xFFFFFFFF), req1 MULH(0x80000000,0x80000000) -> grants 0,1,0,1; results 0xFFFFFFFE on rsp0, 0x40000000 on rsp1.
- Backpressure: rsp1_ready low 10 cycles after rsp1_valid -> result/tag stable, no new grant, busy=1; accept req0 the cycle after rsp1 handshake.
- Flush in WAIT (cycle T+10) -> DRAIN, mul_out_ready=1, no rspN_valid, busy drops after multiplier result drains; next request gives correct result.
- Flush in ISSUE and in RESP -> no mul handshake / response dropped, IDLE next cycle, prio already advanced.
- rst asserted mid-CALC -> all outputs at reset values next cycle; MULHSU(-1, 2) afterward returns 0xFFFFFFFF.
